inverse_state_machine: RTL

Sequential inverse of the team's affine arithmetic pipeline y = (x + 5) * 3 − 7. Given a 32-bit signed y, it recovers x = (y + 7) / 3 − 5 through a start/done state machine built around a multi-cycle restoring divide-by-3. It also flags whether y is an exact image of a 16-bit x. It sits on the decode side of that pipeline and shares its start/done handshake style.

---
 rtl/inverse_state_machine.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/inverse_state_machine.sv
// rtl/inverse_state_machine.sv - recovers x = (y + 7) / 3 - 5 with a start/done FSM and divide-by-3.
// Define INV_SM_FAST_DIV_EN for a single-cycle combinational divide instead of the 33-cycle restoring one.
module inverse_state_machine #(
   parameter int Y_W = 32,
   parameter int X_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic signed [Y_W-1:0] y_in,
   output logic signed [X_W-1:0] x_out,
   output logic                  valid,
   output logic                  busy,
   output logic                  done
);

   localparam int ACC_W = Y_W + 2;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ADD7 = 3'd1;
   localparam logic [2:0] S_DIV3 = 3'd2;
   localparam logic [2:0] S_SUB5 = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam logic signed [ACC_W-1:0] X_MAX = (ACC_W'(1) << (X_W - 1)) - ACC_W'(1);
   localparam logic signed [ACC_W-1:0] X_MIN = -X_MAX - ACC_W'(1);

   logic [2:0]              state;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] sum;
   logic signed [ACC_W-1:0] q_sgn;
   logic signed [ACC_W-1:0] r;
   logic [1:0]              rem;

`ifdef INV_SM_FAST_DIV_EN
   localparam logic signed [ACC_W-1:0] THREE = ACC_W'(3);

   logic signed [ACC_W-1:0] quot;
   logic signed [ACC_W-1:0] q_fast;
   logic signed [ACC_W-1:0] rem_fast;

   always_comb begin
      q_fast   = acc / THREE;
      rem_fast = acc % THREE;
      q_sgn    = quot;
   end
`else
   localparam logic [5:0] LAST_IT = 6'(ACC_W - 2);

   logic [ACC_W-2:0] quot;
   logic [ACC_W-2:0] dvd;
   logic [ACC_W-2:0] mag;
   logic [5:0]       cnt;
   logic             neg;
   logic [2:0]       rem_sh;
   logic             ge;

   always_comb begin
      // |sum| always fits in ACC_W-1 bits, so negate only the low bits
      mag    = (sum[ACC_W-2:0] ^ {(ACC_W-1){sum[ACC_W-1]}})
             + {{(ACC_W-2){1'b0}}, sum[ACC_W-1]};
      rem_sh = {rem, dvd[ACC_W-2]};
      ge     = (rem_sh >= 3'd3);
      q_sgn  = neg ? -{1'b0, quot} : {1'b0, quot};
   end
`endif

   always_comb begin
      sum = acc + ACC_W'(7);
      r   = q_sgn - ACC_W'(5);
   end

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         acc   <= '0;
         quot  <= '0;
         rem   <= '0;
         x_out <= '0;
         valid <= 1'b0;
`ifndef INV_SM_FAST_DIV_EN
         dvd   <= '0;
         neg   <= 1'b0;
         cnt   <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  acc   <= {{2{y_in[Y_W-1]}}, y_in};
                  state <= S_ADD7;
               end
            end
            S_ADD7: begin
               acc   <= sum;
`ifndef INV_SM_FAST_DIV_EN
               neg   <= sum[ACC_W-1];
               dvd   <= mag;
               quot  <= '0;
               rem   <= '0;
               cnt   <= '0;
`endif
               state <= S_DIV3;
            end
            S_DIV3: begin
`ifdef INV_SM_FAST_DIV_EN
               quot  <= q_fast;
               rem   <= {1'b0, rem_fast != '0};
               state <= S_SUB5;
`else
               // rem_sh - 3 lands in 0..2, so mod-4 arithmetic (+1) is exact
               rem  <= ge ? rem_sh[1:0] + 2'd1 : rem_sh[1:0];
               quot <= {quot[ACC_W-3:0], ge};
               dvd  <= {dvd[ACC_W-3:0], 1'b0};
               if (cnt == LAST_IT) begin
                  state <= S_SUB5;
               end else begin
                  cnt <= cnt + 6'd1;
               end
`endif
            end
            S_SUB5: begin
               x_out <= r[X_W-1:0];
               valid <= (rem == 2'd0) && (r >= X_MIN) && (r <= X_MAX);
               state <= S_DONE;
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
